hamming_secded: RTL and testbench
=================================

# hamming_secded

Single-error-correct / double-error-detect (SECDED) demonstrator for one 4-bit nibble. The block encodes the nibble into an extended Hamming(7,4) codeword with one overall parity bit, injects controlled bit flips, decodes and corrects the damaged word, and registers the result with error flags and a hex 7-segment pattern. It sits between board switches and LEDs/display as a self-contained ECC demo and as a reference ECC datapath.

## Interface
- No parameters; widths are fixed.
- `i_clk`  in  1  system clock; all outputs update on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_secded`  in  4  data nibble to protect.
- `i_noise`  in  5  error-injection control: `[2:0]` first flip position (0 = none, 1..7 = codeword position); `[3]` also flip a second Hamming bit; `[4]` flip the overall parity bit p0.
- `o_7seg`  out  7  active-high segments `{g,f,e,d,c,b,a}` showing `o_secded` as a hex digit.
- `o_secded`  out  4  decoded and corrected nibble.
- `o_1bit_error`  out  1  a single Hamming-bit error was detected and corrected.
- `o_2bit_error`  out  1  an uncorrectable double error was detected.
- `o_parity_error`  out  1  only the overall parity bit p0 was wrong.

## Operation
- Codeword positions 1..7 hold p1, p2, d0, p4, d1, d2, d3, where d[3:0] = `i_secded`.
- Parity bits:
  - p1 = d0^d1^d3
  - p2 = d0^d2^d3
  - p4 = d1^d2^d3
  - p0 = XOR of all seven position bits (even overall parity).
- Injection:
  - When `i_noise[2:0]` = k ≠ 0, flip position k.
  - When `i_noise[3]`=1 and k ≠ 0, also flip position (k mod 7)+1, so the two flipped positions always differ. When k=0, `i_noise[3]` is ignored.
  - When `i_noise[4]`=1, flip p0.
- Decode:
  - Syndrome s[2:0] = XOR of the indices of all set bits at positions 1..7.
  - pe = XOR of all 8 received bits.
- Classification (exactly one case applies; the three flags are mutually exclusive):
  - s=0, pe=0: no error. Data passes through; all flags 0.
  - s≠0, pe=1: single error. Invert position s, output the corrected data, `o_1bit_error`=1.
  - s≠0, pe=0: double error. Output the received data bits uncorrected, `o_2bit_error`=1.
  - s=0, pe=1: p0-only error. Data passes through, `o_parity_error`=1.
- Three-bit errors (p0 plus two Hamming bits) are classed as single errors and miscorrected. This is the accepted SECDED limitation.
- 7-segment patterns by hex digit:
  - 0: 0111111
  - 1: 0000110
  - 2: 1011011
  - 3: 1001111
  - 4: 1100110
  - 5: 1101101
  - 6: 1111101
  - 7: 0000111
  - 8: 1111111
  - 9: 1101111
  - A: 1110111
  - b: 1111100
  - C: 0111001
  - d: 1011110
  - E: 1111001
  - F: 1110001

## Timing
- Encode, inject and decode are purely combinational. A single register stage drives all outputs.
- Latency is 1 cycle: inputs sampled at rising edge N appear on the outputs after edge N.
- Inputs are static between edges; there is no handshake.
- Reset asserted (`i_rst_n`=0): all outputs go to 0 immediately, regardless of the clock (`o_7seg` = 0000000, blank).
- Reset deasserted: the first rising edge loads the decoded value of the current inputs.
- Reset arriving mid-stream discards the in-flight value. No other state exists.

## Structure
- Package `hamming_secded_pkg` holds:
  - position constants (P1=1, P2=2, D0=3, P4=4, D1=5, D2=6, D3=7);
  - the flag encoding;
  - the pure function `hex_to_7seg`.
- Sub-module `hamming74_codec` is combinational and contains encode, injection and decode/classify.
- The top level holds only the output register and the 7-segment lookup.

## Test plan
- No errors: `i_noise`=0 and `i_secded`=0..15 → `o_secded` equals the input and all flags 0, one cycle later. Spot checks: 0 → `o_7seg` 0111111; 1010 → 1110111.
- Single error: every `i_secded` with every `i_noise`=1..7 → `o_secded`=`i_secded`, `o_1bit_error`=1, other flags 0.
- Double error: `i_noise`=8|k for k=1..7, all nibbles → `o_2bit_error`=1, `o_1bit_error`=0, `o_parity_error`=0.
- Parity-only error: `i_noise`=10000 → `o_secded`=`i_secded`, `o_parity_error`=1, other flags 0. With k=0, `i_noise`=01000 → behaves as no error.
- Triple error: `i_secded`=8, `i_noise`=11000|k → `o_1bit_error`=1 and `o_secded`≠8 (miscorrection). A following `i_secded`=1010, `i_noise`=0 → clean 1010, flags 0.
- Reset: assert `i_rst_n` low between clock edges → all outputs 0 immediately. After release, the first edge loads the current inputs.

Source files
------------

// File: rtl/hamming_secded_pkg.sv
// Shared constants, error classification and 7-segment lookup for the
// SECDED nibble demonstrator.
package hamming_secded_pkg;

  // Codeword positions; index 0 of an 8-bit word holds the overall parity p0.
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int D0 = 3;
  localparam int P4 = 4;
  localparam int D1 = 5;
  localparam int D2 = 6;
  localparam int D3 = 7;

  // Outcome of decoding one received word; exactly one applies.
  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_SINGLE = 2'd1,
    ERR_DOUBLE = 2'd2,
    ERR_PARITY = 2'd3
  } err_class_t;

  // Active-high segments {g,f,e,d,c,b,a} for a hex digit.
  function automatic logic [6:0] hex_to_7seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      default: seg = 7'b1110001;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hamming74_codec.sv
// Combinational extended Hamming(7,4) path: encode, inject flips, decode
// and classify the received word.
module hamming74_codec
  import hamming_secded_pkg::*;
(
  input  logic [3:0] data,
  input  logic [4:0] noise,
  output logic [3:0] data_out,
  output err_class_t err_class
);

  logic [7:0] code_word;
  logic [7:0] flip_mask;
  logic [7:0] rx_word;
  logic [7:0] fixed_word;
  logic [2:0] first_pos;
  logic [2:0] second_pos;
  logic [2:0] syndrome;
  logic       parity_err;

  // Build the codeword, apply the requested flips, then decode.
  always_comb begin
    code_word     = '0;
    code_word[P1] = data[0] ^ data[1] ^ data[3];
    code_word[P2] = data[0] ^ data[2] ^ data[3];
    code_word[D0] = data[0];
    code_word[P4] = data[1] ^ data[2] ^ data[3];
    code_word[D1] = data[1];
    code_word[D2] = data[2];
    code_word[D3] = data[3];
    code_word[P0] = ^code_word[7:1];

    // Second flip wraps 7 -> 1 so it never lands on the first position.
    first_pos  = noise[2:0];
    second_pos = (first_pos == 3'd7) ? 3'd1 : first_pos + 3'd1;
    flip_mask  = '0;
    if (first_pos != 3'd0) begin
      flip_mask[first_pos] = 1'b1;
      if (noise[3]) begin
        flip_mask[second_pos] = 1'b1;
      end
    end
    if (noise[4]) begin
      flip_mask[P0] = 1'b1;
    end
    rx_word = code_word ^ flip_mask;

    // Syndrome is the XOR of the indices of every set Hamming bit.
    syndrome = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (rx_word[i]) begin
        syndrome = syndrome ^ i[2:0];
      end
    end
    parity_err = ^rx_word;

    fixed_word = rx_word;
    if (syndrome == 3'd0) begin
      err_class = parity_err ? ERR_PARITY : ERR_NONE;
    end else if (parity_err) begin
      err_class            = ERR_SINGLE;
      fixed_word[syndrome] = ~rx_word[syndrome];
    end else begin
      err_class = ERR_DOUBLE;
    end

    data_out = {fixed_word[D3], fixed_word[D2], fixed_word[D1], fixed_word[D0]};
  end

endmodule

// File: rtl/hamming_secded.sv
// SECDED nibble demonstrator: combinational codec followed by a single
// output register stage with flags and a hex 7-segment pattern.
module hamming_secded
  import hamming_secded_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_secded,
  input  logic [4:0] i_noise,
  output logic [6:0] o_7seg,
  output logic [3:0] o_secded,
  output logic       o_1bit_error,
  output logic       o_2bit_error,
  output logic       o_parity_error
);

  logic [3:0] dec_data;
  err_class_t dec_class;

  hamming74_codec u_codec (
    .data      (dec_data_in()),
    .noise     (i_noise),
    .data_out  (dec_data),
    .err_class (dec_class)
  );

  // Identity wrapper keeps the codec input an explicit named expression.
  function automatic logic [3:0] dec_data_in();
    return i_secded;
  endfunction

  // Register decoded data, flags and display; reset blanks everything at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_7seg         <= '0;
      o_secded       <= '0;
      o_1bit_error   <= 1'b0;
      o_2bit_error   <= 1'b0;
      o_parity_error <= 1'b0;
    end else begin
      o_7seg         <= hex_to_7seg(dec_data);
      o_secded       <= dec_data;
      o_1bit_error   <= (dec_class == ERR_SINGLE);
      o_2bit_error   <= (dec_class == ERR_DOUBLE);
      o_parity_error <= (dec_class == ERR_PARITY);
    end
  end

endmodule

// File: tb/tb_hamming_secded.sv
// Self-checking bench for hamming_secded: directed sweeps from the test plan
// plus random stimulus, all compared against a behavioural reference model.
module tb_hamming_secded;

  logic       clk;
  logic       rst_n;
  logic [3:0] secded_in;
  logic [4:0] noise_in;
  logic [6:0] seg_out;
  logic [3:0] secded_out;
  logic       one_err;
  logic       two_err;
  logic       par_err;

  int checks;
  int failures;

  hamming_secded dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_secded       (secded_in),
    .i_noise        (noise_in),
    .o_7seg         (seg_out),
    .o_secded       (secded_out),
    .o_1bit_error   (one_err),
    .o_2bit_error   (two_err),
    .o_parity_error (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display table written directly from the digit shapes.
  function automatic logic [6:0] seg_ref(input int v);
    logic [6:0] t [16];
    t[0]  = 7'b0111111; t[1]  = 7'b0000110; t[2]  = 7'b1011011; t[3]  = 7'b1001111;
    t[4]  = 7'b1100110; t[5]  = 7'b1101101; t[6]  = 7'b1111101; t[7]  = 7'b0000111;
    t[8]  = 7'b1111111; t[9]  = 7'b1101111; t[10] = 7'b1110111; t[11] = 7'b1111100;
    t[12] = 7'b0111001; t[13] = 7'b1011110; t[14] = 7'b1111001; t[15] = 7'b1110001;
    return t[v];
  endfunction

  // Reference: codeword as an int array indexed by position, parity from
  // the rule "p_n covers data positions whose index has bit n set".
  task automatic model(input int d, input int n, output int dout,
                       output int e1, output int e2, output int ep);
    int cw [8];
    int k, syn, pe, cls;
    int dpos [4];
    dpos[0] = 3; dpos[1] = 5; dpos[2] = 6; dpos[3] = 7;
    for (int i = 0; i < 8; i++) cw[i] = 0;
    for (int b = 0; b < 4; b++) cw[dpos[b]] = (d >> b) & 1;
    for (int p = 1; p <= 4; p = p * 2) begin
      int acc;
      acc = 0;
      for (int b = 0; b < 4; b++)
        if ((dpos[b] & p) != 0) acc = acc ^ cw[dpos[b]];
      cw[p] = acc;
    end
    cw[0] = 0;
    for (int i = 1; i < 8; i++) cw[0] = cw[0] ^ cw[i];
    k = n % 8;
    if (k != 0) begin
      cw[k] = 1 - cw[k];
      if (((n >> 3) & 1) == 1) cw[(k % 7) + 1] = 1 - cw[(k % 7) + 1];
    end
    if (((n >> 4) & 1) == 1) cw[0] = 1 - cw[0];
    syn = 0;
    pe  = 0;
    for (int i = 0; i < 8; i++) begin
      if (cw[i] == 1 && i > 0) syn = syn ^ i;
      pe = pe ^ cw[i];
    end
    if (syn == 0) cls = (pe == 1) ? 3 : 0;
    else if (pe == 1) begin
      cls = 1;
      cw[syn] = 1 - cw[syn];
    end else cls = 2;
    dout = 0;
    for (int b = 0; b < 4; b++) dout = dout + (cw[dpos[b]] << b);
    e1 = (cls == 1) ? 1 : 0;
    e2 = (cls == 2) ? 1 : 0;
    ep = (cls == 3) ? 1 : 0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one input pair, clock it, and compare every output with the model.
  task automatic step(input int d, input int n, input string tag);
    int md, m1, m2, mp;
    secded_in = 4'(d);
    noise_in  = 5'(n);
    @(posedge clk);
    #1;
    model(d, n, md, m1, m2, mp);
    chk({tag, ".data"}, int'(secded_out), md);
    chk({tag, ".seg"},  int'(seg_out), int'(seg_ref(md)));
    chk({tag, ".e1"},   int'(one_err), m1);
    chk({tag, ".e2"},   int'(two_err), m2);
    chk({tag, ".ep"},   int'(par_err), mp);
    $display("step %s d=%0h n=%0h -> data=%0h seg=%b flags=%b%b%b",
             tag, d, n, secded_out, seg_out, one_err, two_err, par_err);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    secded_in = 4'd0;
    noise_in  = 5'd0;
    #12;
    chk("reset.seg",  int'(seg_out), 0);
    chk("reset.data", int'(secded_out), 0);
    chk("reset.flags", int'({one_err, two_err, par_err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean words, including pass-through data and flag checks.
    for (int d = 0; d < 16; d++) begin
      step(d, 0, "clean");
      chk("clean.passthru", int'(secded_out), d);
      chk("clean.flags", int'({one_err, two_err, par_err}), 0);
    end
    step(0, 0, "spot0");
    chk("spot0.seg", int'(seg_out), 7'b0111111);
    step(10, 0, "spotA");
    chk("spotA.seg", int'(seg_out), 7'b1110111);

    // Every single Hamming-bit error must be corrected.
    for (int d = 0; d < 16; d++)
      for (int k = 1; k < 8; k++) begin
        step(d, k, "single");
        chk("single.fixed", int'({secded_out, one_err, two_err, par_err}), (d << 3) | 4);
      end

    // Every double error must be flagged and nothing else.
    for (int d = 0; d < 16; d++)
      for (int k = 1; k < 8; k++) begin
        step(d, 8 | k, "double");
        chk("double.flags", int'({one_err, two_err, par_err}), 2);
      end

    // Parity-only error, and noise[3] alone is harmless.
    for (int d = 0; d < 16; d++) begin
      step(d, 16, "parity");
      chk("parity.fixed", int'({secded_out, one_err, two_err, par_err}), (d << 3) | 1);
      step(d, 8, "k0dbl");
      chk("k0dbl.clean", int'({secded_out, one_err, two_err, par_err}), d << 3);
    end

    // Triple errors are miscorrected as singles; then recover cleanly.
    for (int k = 1; k < 8; k++) begin
      step(8, 24 | k, "triple");
      checks++;
      assert (one_err === 1'b1 && secded_out !== 4'd8) else begin
        failures++;
        $error("FAIL triple.miscorrect observed=%0h/%0b expected=!8/1", secded_out, one_err);
      end
    end
    step(10, 0, "recover");
    chk("recover.clean", int'({secded_out, one_err, two_err, par_err}), 10 << 3);

    // Random stimulus against the model.
    for (int r = 0; r < 200; r++)
      step(int'($urandom_range(15, 0)), int'($urandom_range(31, 0)), "rand");

    // Reset between edges clears outputs immediately and holds through an edge.
    step(7, 1, "prerst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.seg",  int'(seg_out), 0);
    chk("midrst.data", int'(secded_out), 0);
    chk("midrst.flags", int'({one_err, two_err, par_err}), 0);
    @(posedge clk);
    #1;
    chk("heldrst.data", int'({secded_out, seg_out}), 0);
    secded_in = 4'd5;
    noise_in  = 5'd16;
    @(negedge clk);
    rst_n = 1'b1;
    step(5, 16, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
